qpu_ifu_ift2itcm: RTL

Bridge between the IFU fetch request/response channels and the instruction TCM (single-port synchronous SRAM). Accepts one fetch request at a time from the ifetch stage and checks its PC for range and alignment. Issues a word read to the ITCM and returns the instruction, or an error response, on the IFU response channel. Holds the response until the ifetch stage accepts it.

---
 rtl/qpu_ifu_ift2itcm.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/qpu_ifu_ift2itcm.sv
// qpu_ifu_ift2itcm
// Bridges the IFU fetch request/response channels to a single-port synchronous
// instruction TCM. One request is outstanding at a time. In-range, word-aligned
// PCs start an ITCM read. Any other PC returns an error response straight away.
// The response is held until the ifetch stage accepts it.

module qpu_ifu_ift2itcm #(
    parameter int                 PC_SIZE    = 32,
    parameter int                 INSTR_SIZE = 32,
    parameter int                 ITCM_AW    = 12,
    parameter logic [PC_SIZE-1:0] ITCM_BASE  = PC_SIZE'(32'h8000_0000),
    parameter int                 RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    input  logic                  ifu_req_seq,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_rsp_err,
    output logic                  itcm_cs,
    output logic [ITCM_AW-1:0]    itcm_addr,
    input  logic [INSTR_SIZE-1:0] itcm_rdata,
    output logic                  busy
);

    // The counter holds at most RD_LAT-1 (0..3), so two bits are enough.
    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [INSTR_SIZE-1:0]   rsp_instr_q, rsp_instr_d;
    logic                    rsp_err_q, rsp_err_d;
    // The sequential hint is captured for future use and has no effect today.
    logic                    unused_seq_q;

    logic req_hsk;
    logic rsp_hsk;
    logic in_range;
    logic aligned;
    logic good_req;

    // A new request is taken when idle, or while a response is being retired.
    assign ifu_req_ready = (state_q == ST_IDLE) | ((state_q == ST_RSP) & ifu_rsp_ready);
    assign req_hsk       = ifu_req_valid & ifu_req_ready;
    assign rsp_hsk       = ifu_rsp_valid & ifu_rsp_ready;

    // The ITCM is aligned to its own size, so the range check only compares the
    // PC bits above the word-address field.
    assign in_range = (ifu_req_pc[PC_SIZE-1:ITCM_AW+2] == ITCM_BASE[PC_SIZE-1:ITCM_AW+2]);
    assign aligned  = (ifu_req_pc[1:0] == 2'b00);
    assign good_req = in_range & aligned;

    // The ITCM strobe comes combinationally from the handshake. The address follows the PC.
    assign itcm_cs   = req_hsk & good_req;
    assign itcm_addr = ifu_req_pc[ITCM_AW+1:2];

    assign ifu_rsp_valid = (state_q == ST_RSP);
    assign ifu_rsp_instr = rsp_instr_q;
    assign ifu_rsp_err   = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);

    // Next-state logic: accept, wait out the read latency, then hold the response.
    always_comb begin
        // NOTE: every target gets a default before the case statement. Without it,
        // a path that skips an assignment infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_instr_d = rsp_instr_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_hsk) begin
                    if (good_req) begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        rsp_instr_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RSP;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_instr_d = itcm_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RSP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RSP: begin
                if (rsp_hsk) begin
                    if (req_hsk) begin
                        // A back-to-back request starts exactly as it would from idle.
                        if (good_req) begin
                            cnt_d   = CNT_LOAD;
                            state_d = ST_WAIT;
                        end else begin
                            rsp_instr_d = '0;
                            rsp_err_d   = 1'b1;
                            state_d     = ST_RSP;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, latency counter and response register. Reset discards any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every register then
            // samples the values from before the clock edge, whatever the statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Capture the sequential-fetch hint with each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unused_seq_q <= 1'b0;
        end else if (req_hsk) begin
            unused_seq_q <= ifu_req_seq;
        end
    end

endmodule
